cdc: RTL and testbench



---
 rtl/cdc_if.sv | 35 +++
 rtl/cdc.sv | 84 ++++++++
 tb/tb_cdc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_if.sv
// ---------------------------------------------------------------------------
// cdc_if
// Bundles the level crossing into the destination domain and the clean,
// filtered results coming back out of the synchronizer.
//
// Signals:
//   i_signal : asynchronous, possibly glitchy level entering the block
//   o_signal : synchronized and filtered level
//   o_rise   : one-cycle strobe when o_signal goes 0->1
//   o_fall   : one-cycle strobe when o_signal goes 1->0
//
// Modports:
//   slave  : the synchronizer itself (consumes i_signal, produces outputs)
//   master : whoever supplies the raw level and consumes the clean outputs
// ---------------------------------------------------------------------------
interface cdc_if;
    logic i_signal;
    logic o_signal;
    logic o_rise;
    logic o_fall;

    modport slave (
        input  i_signal,
        output o_signal,
        output o_rise,
        output o_fall
    );

    modport master (
        output i_signal,
        input  o_signal,
        input  o_rise,
        input  o_fall
    );
endinterface

// File: rtl/cdc.sv
// ---------------------------------------------------------------------------
// cdc
// Single-bit clock-domain-crossing synchronizer with a stability filter.
// An asynchronous level is passed through a plain flop chain, and the
// resulting synchronized value only reaches o_signal once it has disagreed
// with the current output for FILTER_LEN consecutive cycles. Registered
// rise/fall strobes accompany every output change.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth (>= 2)
//   FILTER_LEN  : consecutive differing cycles needed to update (>= 1)
//   RESET_VALUE : level of the chain and o_signal while in reset
//
// Ports:
//   i_clk : destination-domain clock, rising edge
//   i_rst : asynchronous reset, active low
//   bus   : cdc_if.slave (i_signal in; o_signal, o_rise, o_fall out)
// ---------------------------------------------------------------------------
module cdc #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic  i_clk,
    input  logic  i_rst,
    cdc_if.slave  bus
);

    // A filter of length 1 still needs a 1-bit counter so the
    // "count reached" compare stays well formed.
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic                   sig_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchronizer chain: sync[0] samples the raw pin, every further stage
    // copies its predecessor. Nothing sits between the flops so each stage
    // gets a full cycle to resolve metastability.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.i_signal};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Stability filter. Any cycle where the synchronized level agrees with
    // the output clears the count, so a disagreement must be uninterrupted
    // for FILTER_LEN cycles before the output follows. The strobes are set
    // on the same edge as the output update and cleared on every other edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt    <= '0;
            sig_q  <= RESET_VALUE;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s == sig_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sig_q  <= s;
                cnt    <= '0;
                rise_q <= s;
                fall_q <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_signal = sig_q;
    assign bus.o_rise   = rise_q;
    assign bus.o_fall   = fall_q;

endmodule

// File: tb/tb_cdc.sv
// ---------------------------------------------------------------------------
// tb_cdc
// Drives two synchronizer instances: dut_a with default parameters and
// dut_b with SYNC_STAGES=3, FILTER_LEN=1, RESET_VALUE=0. dut_a is compared
// every cycle against a reference model built from a history queue of
// sampled inputs and a run-length rule; directed sequences add exact
// edge-count expectations for reset, clean edges, glitches, reset during
// filtering, the alternate parameter set and fast toggling.
// ---------------------------------------------------------------------------
module tb_cdc;

    localparam int A_SYNC   = 2;
    localparam int A_FILTER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_a = 1'b0;
    logic sig_b = 1'b0;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    cdc_if if_a ();
    cdc_if if_b ();

    assign if_a.i_signal = sig_a;
    assign if_b.i_signal = sig_b;

    cdc #(
        .SYNC_STAGES (A_SYNC),
        .FILTER_LEN  (A_FILTER),
        .RESET_VALUE (1'b1)
    ) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a)
    );

    cdc #(
        .SYNC_STAGES (3),
        .FILTER_LEN  (1),
        .RESET_VALUE (1'b0)
    ) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    // Reference model for dut_a. hist holds the raw samples still in flight
    // through the synchronizer, oldest first; the oldest is the level the
    // filter sees on this edge. The output flips once that level has
    // disagreed with it on A_FILTER consecutive edges.
    logic hist[$];
    logic m_sig  = 1'b1;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run  = 0;

    always @(posedge clk or negedge rst) begin
        logic s_now;
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < A_SYNC; i++) hist.push_back(1'b1);
            m_sig  = 1'b1;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
        end else begin
            s_now = hist.pop_front();
            hist.push_back(sig_a);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s_now == m_sig) begin
                m_run = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run == A_FILTER) begin
                    m_sig  = s_now;
                    m_rise = s_now;
                    m_fall = !s_now;
                    m_run  = 0;
                end
            end
        end
    end

    // Compare dut_a with the model on every falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("model_sig",  if_a.o_signal, m_sig);
            checkOutput("model_rise", if_a.o_rise,   m_rise);
            checkOutput("model_fall", if_a.o_fall,   m_fall);
        end
    end

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic val);
        sig_a = val;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic sig, input logic rise, input logic fall);
        checkOutput({tag, "_sig"},  if_a.o_signal, sig);
        checkOutput({tag, "_rise"}, if_a.o_rise,   rise);
        checkOutput({tag, "_fall"}, if_a.o_fall,   fall);
    endtask

    // After the input has been set to new_val, the output must hold its old
    // level for n-1 edges, show new_val with the matching strobe on edge n,
    // and drop the strobe on the following edge.
    task automatic expectEdges(input string tag, input logic new_val, input int n);
        for (int k = 1; k <= n; k++) begin
            stepEdge();
            if (k < n) checkA(tag, !new_val, 1'b0, 1'b0);
            else       checkA(tag, new_val, new_val, !new_val);
        end
        stepEdge();
        checkA({tag, "_after"}, new_val, 1'b0, 1'b0);
    endtask

    initial begin
        int level;
        int hold;

        #1 rst = 1'b0;
        repeat (3) stepEdge();
        checkA("reset", 1'b1, 1'b0, 1'b0);
        checkOutput("reset_b_sig",  if_b.o_signal, 1'b0);
        checkOutput("reset_b_rise", if_b.o_rise,   1'b0);
        model_on = 1'b1;

        // Release with the input held low: falls on edge 5.
        rst = 1'b1;
        expectEdges("release_fall", 1'b0, 5);

        // Clean edges with defaults.
        applyStimulus(1'b1);
        expectEdges("clean_rise", 1'b1, 5);
        applyStimulus(1'b0);
        expectEdges("clean_fall", 1'b0, 5);
        applyStimulus(1'b1);
        expectEdges("clean_rise2", 1'b1, 5);

        // Alternate parameter set: 3 sync stages, no filtering, rise on edge 4.
        sig_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            stepEdge();
            checkOutput("sweep_sig",  if_b.o_signal, (k >= 4) ? 1'b1 : 1'b0);
            checkOutput("sweep_rise", if_b.o_rise,   (k == 4) ? 1'b1 : 1'b0);
            checkOutput("sweep_fall", if_b.o_fall,   1'b0);
        end

        // Two-cycle low glitch must be swallowed.
        applyStimulus(1'b0);
        repeat (2) stepEdge();
        applyStimulus(1'b1);
        for (int k = 1; k <= 8; k++) begin
            stepEdge();
            checkA("glitch2", 1'b1, 1'b0, 1'b0);
        end

        // Three-cycle low pulse passes: low during edges 5..7 only.
        applyStimulus(1'b0);
        for (int k = 1; k <= 12; k++) begin
            stepEdge();
            checkA("glitch3", (k >= 5 && k < 8) ? 1'b0 : 1'b1,
                   (k == 8) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0);
            if (k == 3) applyStimulus(1'b1);
        end

        // Reset on edge 4 of a pending fall discards the count.
        applyStimulus(1'b0);
        repeat (4) stepEdge();
        rst = 1'b0;
        #1;
        checkA("midreset", 1'b1, 1'b0, 1'b0);
        repeat (2) begin
            stepEdge();
            checkA("midreset_hold", 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b1;
        expectEdges("midreset_release", 1'b0, 5);

        // Reset while the output is low forces it high without a clock edge.
        applyStimulus(1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkA("async_reset", 1'b1, 1'b0, 1'b0);
        stepEdge();
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            stepEdge();
            checkA("async_after", 1'b1, 1'b0, 1'b0);
        end

        // Toggling every cycle never settles long enough to pass.
        for (int k = 0; k < 50; k++) begin
            applyStimulus(!sig_a);
            stepEdge();
            checkA("toggle", 1'b1, 1'b0, 1'b0);
        end

        // Random level holds, checked only against the model.
        for (int k = 0; k < 150; k++) begin
            level = $urandom_range(0, 1);
            hold  = $urandom_range(1, 7);
            applyStimulus(level[0]);
            repeat (hold) stepEdge();
        end

        repeat (2) stepEdge();
        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
